led_rom_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 21 ++
 rtl/led_tick_gen.sv | 36 +++
 rtl/led_rom_sequencer.sv | 113 +++++++++++
 tb/tb_led_rom_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and field layout for the LED ROM sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_seq_pkg;

    localparam int ADDR_W  = 8;
    localparam int WORD_W  = 16;

    // Step word layout: pattern in the upper byte, duration in ticks in the lower byte
    localparam int PAT_MSB = 15;
    localparam int PAT_LSB = 8;
    localparam int DUR_MSB = 7;
    localparam int DUR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Display-tick prescaler: pulses tick once every TICK_DIV enabled cycles.
// Latency: first tick on the TICK_DIV-th enabled cycle after clr.
// Backpressure: none; clr has priority over en and holds the count at zero.
// Ports: clk/rst_n clock and async active-low reset; clr restarts the count;
//        en advances it; tick is combinational from the count register.
module led_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A 1-bit counter is kept even for TICK_DIV=1 so the width is never zero
    localparam int          CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_pre;
    logic          w_last;

    assign w_last = (r_pre == LAST);
    assign tick   = en && !clr && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_last ? '0 : r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/led_rom_sequencer.sv
// LED program sequencer: fetches step words from a zero-latency ROM, shows each pattern for its tick count.
// Latency: start sampled at E0 -> first pattern on leds after E1; each step lasts dur*TICK_DIV+1 cycles.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE on the next edge.
// Ports: clk/rst_n; start/stop controls; rom_addr/rom_data ROM bus; leds pattern drive;
//        busy (not IDLE); done (one-cycle pulse on normal program end).
module led_rom_sequencer
    import led_seq_pkg::*;
#(
    parameter int                TICK_DIV   = 1,
    parameter logic [ADDR_W-1:0] START_ADDR = 8'd0,
    parameter bit                LOOP       = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [7:0]        leds,
    output logic              busy,
    output logic              done
);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_leds;
    logic [7:0]        r_cnt;
    logic              r_shown;
    logic              r_done;

    logic [7:0] w_pat;
    logic [7:0] w_dur;
    logic       w_tick;
    logic       w_pre_clr;
    logic       w_pre_en;

    assign w_pat = rom_data[PAT_MSB:PAT_LSB];
    assign w_dur = rom_data[DUR_MSB:DUR_LSB];

    // Prescaler only runs while a pattern is held; any other state parks it at zero
    assign w_pre_en  = (r_state == SHOW);
    assign w_pre_clr = (r_state != SHOW);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_pre_clr),
        .en    (w_pre_en),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= START_ADDR;
            r_leds  <= 8'h00;
            r_cnt   <= 8'h00;
            r_shown <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop && (r_state != IDLE)) begin
                // Abort keeps the address so a debugger can see where it stopped
                r_state <= IDLE;
                r_leds  <= 8'h00;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !stop) begin
                            r_addr  <= START_ADDR;
                            r_shown <= 1'b0;
                            r_state <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (w_dur != 8'h00) begin
                            r_leds  <= w_pat;
                            r_cnt   <= w_dur;
                            r_shown <= 1'b1;
                            r_state <= SHOW;
                        end else if (LOOP && r_shown) begin
                            // Wrap only if this pass showed something, so an empty program halts
                            r_addr  <= START_ADDR;
                            r_shown <= 1'b0;
                        end else begin
                            r_leds  <= 8'h00;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    SHOW: begin
                        if (w_tick) begin
                            r_cnt <= r_cnt - 8'd1;
                            if (r_cnt == 8'd1) begin
                                r_addr  <= r_addr + 8'd1;
                                r_state <= FETCH;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign rom_addr = r_addr;
    assign leds     = r_leds;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_led_rom_sequencer.sv
module tb_led_rom_sequencer;

    logic        clk;
    logic        rst_n;
    logic        st [5];
    logic        sp [5];
    logic [7:0]  ra [5];
    logic [15:0] rd [5];
    logic [7:0]  ld [5];
    logic        bz [5];
    logic        dn [5];
    logic [15:0] mem4 [256];

    int n_cmp = 0;
    int n_bad = 0;

    // u0: plain run, u1: looping, u2: prescaled, u3: empty program, u4: random programs with address wrap
    led_rom_sequencer #(.TICK_DIV(1), .START_ADDR(8'd0), .LOOP(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .stop(sp[0]), .rom_addr(ra[0]),
        .rom_data(rd[0]), .leds(ld[0]), .busy(bz[0]), .done(dn[0]));
    led_rom_sequencer #(.TICK_DIV(1), .START_ADDR(8'd0), .LOOP(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .stop(sp[1]), .rom_addr(ra[1]),
        .rom_data(rd[1]), .leds(ld[1]), .busy(bz[1]), .done(dn[1]));
    led_rom_sequencer #(.TICK_DIV(4), .START_ADDR(8'd0), .LOOP(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .stop(sp[2]), .rom_addr(ra[2]),
        .rom_data(rd[2]), .leds(ld[2]), .busy(bz[2]), .done(dn[2]));
    led_rom_sequencer #(.TICK_DIV(1), .START_ADDR(8'd8), .LOOP(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .stop(sp[3]), .rom_addr(ra[3]),
        .rom_data(rd[3]), .leds(ld[3]), .busy(bz[3]), .done(dn[3]));
    led_rom_sequencer #(.TICK_DIV(2), .START_ADDR(8'd250), .LOOP(1'b0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .stop(sp[4]), .rom_addr(ra[4]),
        .rom_data(rd[4]), .leds(ld[4]), .busy(bz[4]), .done(dn[4]));

    // Production ROM: 0..7 walk a single lit LED from bit 7 to bit 0, 128 ticks each
    function automatic logic [15:0] prod_rom(input logic [7:0] a);
        logic [7:0] pat;
        if (a < 8'd8) begin
            pat = 8'h80 >> a;
            return {pat, 8'h80};
        end else begin
            return 16'h0000;
        end
    endfunction

    assign rd[0] = prod_rom(ra[0]);
    assign rd[1] = prod_rom(ra[1]);
    assign rd[2] = prod_rom(ra[2]);
    assign rd[3] = prod_rom(ra[3]);
    assign rd[4] = mem4[ra[4]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Production-program timeline, e = edges since the start edge E0.
    // A step lasts p = 128*td+1 cycles; a loop pass adds one wrap FETCH cycle.
    function automatic logic [7:0] m_leds(input int e, input int td, input bit loop);
        int p;
        int k;
        p = 128 * td + 1;
        if (e < 1) return 8'h00;
        if (loop) begin
            k = ((e - 1) % (8 * p + 1)) / p;
            if (k >= 8) return 8'h01;
            return 8'h80 >> k;
        end
        if (e - 1 >= 8 * p) return 8'h00;
        k = (e - 1) / p;
        return 8'h80 >> k;
    endfunction

    function automatic logic [7:0] m_addr(input int e, input int td, input bit loop);
        int p;
        p = 128 * td + 1;
        if (loop) return 8'((e % (8 * p + 1)) / p);
        if (e / p > 8) return 8'd8;
        return 8'(e / p);
    endfunction

    function automatic logic m_busy(input int e, input int td, input bit loop);
        if (loop) return 1'b1;
        return (e <= 8 * (128 * td + 1));
    endfunction

    function automatic logic m_done(input int e, input int td, input bit loop);
        if (loop) return 1'b0;
        return (e == 8 * (128 * td + 1) + 1);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_prod(input int u, input int e, input int td, input bit loop);
        chk($sformatf("u%0d leds e%0d", u, e), ld[u], m_leds(e, td, loop));
        chk($sformatf("u%0d addr e%0d", u, e), ra[u], m_addr(e, td, loop));
        chk($sformatf("u%0d busy e%0d", u, e), bz[u], m_busy(e, td, loop));
        chk($sformatf("u%0d done e%0d", u, e), dn[u], m_done(e, td, loop));
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s u%0d leds", tag, i), ld[i], 8'h00);
            chk($sformatf("%s u%0d busy", tag, i), bz[i], 1'b0);
            chk($sformatf("%s u%0d done", tag, i), dn[i], 1'b0);
        end
        chk({tag, " u0 addr"}, ra[0], 8'd0);
        chk({tag, " u3 addr"}, ra[3], 8'd8);
        chk({tag, " u4 addr"}, ra[4], 8'd250);
    endtask

    logic [7:0] q_leds [$];
    logic [7:0] q_addr [$];
    logic       q_busy [$];
    logic       q_done [$];

    initial begin
        for (int i = 0; i < 5; i++) begin
            st[i] = 1'b0;
            sp[i] = 1'b0;
        end
        for (int a = 0; a < 256; a++) mem4[a] = 16'h0000;
        rst_n = 1'b0;
        #23;
        chk_reset("reset");
        rst_n = 1'b1;
        edge1();
        edge1();
        chk_reset("idle");

        // Full run, loop, prescaler and empty program all started on the same edge
        for (int i = 0; i < 4; i++) st[i] = 1'b1;
        edge1();
        for (int i = 0; i < 4; i++) st[i] = 1'b0;
        for (int e = 0; e <= 1040; e++) begin
            if (e > 0) edge1();
            chk_prod(0, e, 1, 1'b0);
            chk_prod(1, e, 1, 1'b1);
            chk_prod(2, e, 4, 1'b0);
            if (e <= 3) begin
                chk($sformatf("u3 busy e%0d", e), bz[3], (e == 0));
                chk($sformatf("u3 done e%0d", e), dn[3], (e == 1));
                chk($sformatf("u3 leds e%0d", e), ld[3], 8'h00);
            end
        end

        // Abort the still-running instances
        sp[1] = 1'b1;
        sp[2] = 1'b1;
        edge1();
        sp[1] = 1'b0;
        sp[2] = 1'b0;
        chk("u1 stop busy", bz[1], 1'b0);
        chk("u1 stop leds", ld[1], 8'h00);
        chk("u2 stop busy", bz[2], 1'b0);
        chk("u2 stop done", dn[2], 1'b0);

        // Stop mid-SHOW at E50
        st[0] = 1'b1;
        edge1();
        st[0] = 1'b0;
        for (int e = 0; e < 50; e++) begin
            if (e > 0) edge1();
            chk_prod(0, e, 1, 1'b0);
        end
        sp[0] = 1'b1;
        edge1();
        sp[0] = 1'b0;
        chk("stop50 leds", ld[0], 8'h00);
        chk("stop50 busy", bz[0], 1'b0);
        chk("stop50 done", dn[0], 1'b0);
        chk("stop50 addr", ra[0], 8'd0);
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk($sformatf("post-stop done c%0d", i), dn[0], 1'b0);
        end

        // start together with stop must not launch a run
        st[0] = 1'b1;
        sp[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk($sformatf("start+stop busy c%0d", i), bz[0], 1'b0);
        end
        sp[0] = 1'b0;

        // This edge starts a run; stop it at E200 so the held address is nonzero
        edge1();
        st[0] = 1'b0;
        for (int e = 1; e < 200; e++) begin
            edge1();
            chk_prod(0, e, 1, 1'b0);
        end
        sp[0] = 1'b1;
        edge1();
        sp[0] = 1'b0;
        chk("stop200 addr held", ra[0], 8'd1);
        chk("stop200 busy", bz[0], 1'b0);

        // Restart begins from the first address again, then reset mid step 2
        st[0] = 1'b1;
        edge1();
        st[0] = 1'b0;
        chk("restart addr", ra[0], 8'd0);
        for (int e = 1; e <= 300; e++) begin
            edge1();
            chk_prod(0, e, 1, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        edge1();
        chk_reset("held");
        #3;
        rst_n = 1'b1;
        edge1();
        st[0] = 1'b1;
        edge1();
        st[0] = 1'b0;
        edge1();
        chk("replay leds", ld[0], 8'h80);
        chk("replay busy", bz[0], 1'b1);

        // Random programs on u4, starting at 250 so the address wraps past 255
        for (int t = 0; t < 6; t++) begin
            int n;
            int hold;
            int base;
            logic [7:0] pat;
            logic [7:0] dur;
            for (int a = 0; a < 256; a++) mem4[a] = 16'h0000;
            q_leds.delete();
            q_addr.delete();
            q_busy.delete();
            q_done.delete();
            n    = $urandom_range(6, 10);
            hold = $urandom_range(1, 3);
            base = 250;
            q_leds.push_back(8'h00);
            q_addr.push_back(8'(base));
            q_busy.push_back(1'b1);
            q_done.push_back(1'b0);
            for (int i = 0; i < n; i++) begin
                pat = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                dur = 8'($urandom_range(1, 4));
                mem4[(base + i) % 256] = {pat, dur};
                for (int c = 0; c <= 2 * dur; c++) begin
                    q_leds.push_back(pat);
                    q_addr.push_back(8'((c == 2 * dur) ? (base + i + 1) % 256 : (base + i) % 256));
                    q_busy.push_back(1'b1);
                    q_done.push_back(1'b0);
                end
            end
            q_leds.push_back(8'h00);
            q_addr.push_back(8'((base + n) % 256));
            q_busy.push_back(1'b0);
            q_done.push_back(1'b1);
            q_leds.push_back(8'h00);
            q_addr.push_back(8'((base + n) % 256));
            q_busy.push_back(1'b0);
            q_done.push_back(1'b0);

            repeat ($urandom_range(0, 3)) edge1();
            st[4] = 1'b1;
            for (int e = 0; e < q_leds.size(); e++) begin
                edge1();
                if (e + 1 >= hold) st[4] = 1'b0;
                chk($sformatf("r%0d leds e%0d", t, e), ld[4], q_leds[e]);
                chk($sformatf("r%0d addr e%0d", t, e), ra[4], q_addr[e]);
                chk($sformatf("r%0d busy e%0d", t, e), bz[4], q_busy[e]);
                chk($sformatf("r%0d done e%0d", t, e), dn[4], q_done[e]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
